// File: rtl/serial_queue_bridge.sv
// serial_queue_bridge
//   Assembles DATA_W-bit words from a qualified serial bit stream (MSB first)
//   and hands each completed word to a DEPTH-entry FIFO. Deserializer sampling
//   and queue operations run on one-cycle enables from two free-running
//   counters (DES_DIV and Q_DIV cycles apart). No derived clocks are generated.
//
//   Optional feature macro: DROP_OLDEST_EN
//     defined   : a push into a full FIFO with no pop on the same edge discards
//                 the oldest entry and writes the new word.
//     undefined : that push is refused and the word waits in HOLD.
//
// Ports
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   data_in     in   serial data bit
//   write_in    in   qualifies data_in
//   enqueue_in  in   permits transfer of the pending word into the FIFO
//   dequeue_in  in   requests a FIFO pop
//   status_out  out  high while the deserializer accepts bits
//   data_ready  out  high while an assembled word is pending
//   data_out    out  most recently dequeued word
//   len_out     out  current FIFO occupancy, 0..DEPTH
module serial_queue_bridge #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 8,
  parameter int DES_DIV = 10,
  parameter int Q_DIV   = 100
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         data_in,
  input  logic                         write_in,
  input  logic                         enqueue_in,
  input  logic                         dequeue_in,
  output logic                         status_out,
  output logic                         data_ready,
  output logic [DATA_W-1:0]            data_out,
  output logic [$clog2(DEPTH+1)-1:0]   len_out
);

  localparam int LEN_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DCNT_W = (DES_DIV > 1) ? $clog2(DES_DIV) : 1;
  localparam int QCNT_W = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
  localparam int BCNT_W = $clog2(DATA_W + 1);

  localparam logic [DCNT_W-1:0] DES_LAST = DCNT_W'(DES_DIV - 1);
  localparam logic [QCNT_W-1:0] Q_LAST   = QCNT_W'(Q_DIV - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_FULL = LEN_W'(DEPTH);
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W - 1);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [DCNT_W-1:0]   des_cnt;
  logic [QCNT_W-1:0]   q_cnt;
  logic                des_tick;
  logic                q_tick;
  logic [DATA_W-1:0]   shift;
  logic [BCNT_W-1:0]   bit_cnt;
  logic                capture;
  logic                push;
  logic                pop;
  logic                drop;
  logic                ack;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [DATA_W-1:0]   mem [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Tick generators: count 0..DIV-1, tick while the count sits at DIV-1
  assign des_tick = (des_cnt == DES_LAST);
  assign q_tick   = (q_cnt == Q_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      des_cnt <= '0;
      q_cnt   <= '0;
    end else begin
      des_cnt <= des_tick ? '0 : des_cnt + DCNT_W'(1);
      q_cnt   <= q_tick ? '0 : q_cnt + QCNT_W'(1);
    end
  end

  // Deserializer control
  assign capture = des_tick && write_in && (state == COLLECT);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    status_out = 1'b0;
    data_ready = 1'b0;
    case (state)
      COLLECT: begin
        status_out = 1'b1;
        if (capture && (bit_cnt == BIT_LAST)) state_nxt = HOLD;
      end
      HOLD: begin
        data_ready = 1'b1;
        if (ack) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  // Shift register and bit count; capture and ack are mutually exclusive
  // because one needs COLLECT and the other HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift   <= '0;
      bit_cnt <= '0;
    end else if (capture) begin
      shift   <= DATA_W'({shift, data_in});
      bit_cnt <= bit_cnt + BCNT_W'(1);
    end else if (ack) begin
      bit_cnt <= '0;
    end
  end

  // Queue decisions. A pop needs a non-empty FIFO, so push+pop on an empty
  // FIFO degenerates to a plain push.
  assign pop = q_tick && dequeue_in && (len_out != '0);

`ifdef DROP_OLDEST_EN
  assign drop = q_tick && enqueue_in && data_ready && (len_out == LEN_FULL) && !pop;
  assign push = q_tick && enqueue_in && data_ready;
`else
  assign drop = 1'b0;
  assign push = q_tick && enqueue_in && data_ready && ((len_out != LEN_FULL) || pop);
`endif

  // The deserializer releases its word on the same edge the FIFO takes it
  assign ack = push;

  always_ff @(posedge clock) begin
    if (push) mem[tail] <= shift;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      len_out  <= '0;
      data_out <= '0;
    end else begin
      if (push) tail <= ptr_inc(tail);
      // A drop retires the oldest entry exactly like a pop, minus the output
      if (pop || drop) head <= ptr_inc(head);
      if (pop) data_out <= mem[head];
      // A dropping push leaves occupancy at DEPTH
      case ({push && !drop, pop})
        2'b10:   len_out <= len_out + LEN_W'(1);
        2'b01:   len_out <= len_out - LEN_W'(1);
        default: len_out <= len_out;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_queue_bridge.sv
// tb_serial_queue_bridge
//   Directed bench for serial_queue_bridge with a queue-based scoreboard.
//   Words shifted in are tracked as the pending word; pushes move it into a
//   model queue and pops compare data_out against the model's head.
//   Tick timing is modelled by bench-side counters cleared by reset.
//   Works with or without DROP_OLDEST_EN defined.
module tb_serial_queue_bridge;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 8;
  localparam int DES_DIV = 4;
  localparam int Q_DIV   = 64;
  localparam int LEN_W   = $clog2(DEPTH + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              data_in = 1'b0;
  logic              write_in = 1'b0;
  logic              enqueue_in = 1'b0;
  logic              dequeue_in = 1'b0;
  logic              status_out;
  logic              data_ready;
  logic [DATA_W-1:0] data_out;
  logic [LEN_W-1:0]  len_out;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cyc_r = 0;
  int dcnt = 0;
  int qcnt = 0;

  logic [DATA_W-1:0] sb [$];
  logic              m_ready = 1'b0;
  logic [DATA_W-1:0] m_word = '0;
  logic [DATA_W-1:0] exp_out = '0;

  serial_queue_bridge #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .DES_DIV(DES_DIV),
    .Q_DIV  (Q_DIV)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .write_in  (write_in),
    .enqueue_in(enqueue_in),
    .dequeue_in(dequeue_in),
    .status_out(status_out),
    .data_ready(data_ready),
    .data_out  (data_out),
    .len_out   (len_out)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (reset) begin
      dcnt <= 0;
      qcnt <= 0;
    end else begin
      dcnt <= (dcnt == DES_DIV - 1) ? 0 : dcnt + 1;
      qcnt <= (qcnt == Q_DIV - 1) ? 0 : qcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_des();
    int n = 0;
    @(negedge clock);
    while (dcnt != DES_DIV - 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      errors++;
      $error("FAIL des_wait observed=%0d expected=<100", n);
    end
  endtask

  task automatic send_bit(input logic b);
    wait_des();
    write_in = 1'b1;
    data_in  = b;
    @(negedge clock);
    write_in = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    chk("status_collect", status_out, 1);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      send_bit(w[i]);
      if (i == 1) chk("ready_early", data_ready, 0);
    end
    m_ready = 1'b1;
    m_word  = w;
    chk("ready_hold", data_ready, 1);
    chk("status_hold", status_out, 0);
  endtask

  // Unqualified bits on des ticks and qualified bits off-tick must be ignored
  task automatic send_word_noisy(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) begin
      wait_des();
      write_in = 1'b0;
      data_in  = ~w[i];
      @(negedge clock);
      write_in = 1'b1;
      data_in  = ~w[i];
      @(negedge clock);
      write_in = 1'b0;
      send_bit(w[i]);
    end
    m_ready = 1'b1;
    m_word  = w;
    chk("noisy_ready", data_ready, 1);
  endtask

  task automatic q_op(input logic enq, input logic deq);
    int n = 0;
    logic do_pop;
    logic do_push;
    logic [DATA_W-1:0] tmp;
    @(negedge clock);
    while (qcnt != Q_DIV - 1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      errors++;
      $error("FAIL q_wait observed=%0d expected=<200", n);
    end
    enqueue_in = enq;
    dequeue_in = deq;
    @(negedge clock);
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    do_pop = deq && (sb.size() > 0);
`ifdef DROP_OLDEST_EN
    do_push = enq && m_ready;
`else
    do_push = enq && m_ready && ((sb.size() < DEPTH) || do_pop);
`endif
    if (do_pop) exp_out = sb.pop_front();
    if (do_push) begin
      if (sb.size() == DEPTH) tmp = sb.pop_front();
      sb.push_back(m_word);
      m_ready = 1'b0;
    end
    chk("len", len_out, sb.size());
    chk("data_out", data_out, exp_out);
    chk("data_ready", data_ready, m_ready);
    chk("status", status_out, !m_ready);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset      = 1'b1;
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("rst_status", status_out, 1);
    chk("rst_ready", data_ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_len", len_out, 0);
    reset = 1'b0;
    cyc_r = cyc;
    sb.delete();
    m_ready = 1'b0;
    exp_out = '0;
  endtask

  initial begin
    do_reset();

    // Basic word through the queue
    send_word(8'hA5);
    q_op(1'b1, 1'b0);
    q_op(1'b0, 1'b1);

    // Pop while empty is ignored
    q_op(1'b0, 1'b1);

    // Qualifier filtering
    send_word_noisy(8'h3C);
    q_op(1'b1, 1'b0);
    q_op(1'b0, 1'b1);

    // Fill, then offer one more word to a full FIFO
    for (int w = 1; w <= DEPTH; w++) begin
      send_word(DATA_W'(w));
      q_op(1'b1, 1'b0);
    end
    send_word(8'h09);
    q_op(1'b1, 1'b0);

    // Simultaneous push/pop while full
    if (!m_ready) send_word(8'h0A);
    q_op(1'b1, 1'b1);

    // Drain (pointers have wrapped by now)
    for (int i = 0; i < DEPTH; i++) q_op(1'b0, 1'b1);
    q_op(1'b0, 1'b1);

    // Simultaneous push/pop while empty
    send_word(8'h5A);
    q_op(1'b1, 1'b1);
    q_op(1'b0, 1'b1);

    // Reset mid-word with a queued entry
    send_word(8'h77);
    q_op(1'b1, 1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    do_reset();

    // Fresh word after reset, and first queue tick timing
    send_word(8'hFF);
    enqueue_in = 1'b1;
    while (cyc - cyc_r < Q_DIV - 1) @(negedge clock);
    chk("pre_first_qtick_len", len_out, 0);
    @(negedge clock);
    enqueue_in = 1'b0;
    chk("first_qtick_len", len_out, 1);
    sb.push_back(8'hFF);
    m_ready = 1'b0;
    chk("first_qtick_ready", data_ready, 0);
    q_op(1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
